// File: rtl/counter_ctrl_cond_pkg.sv
// ============================================================================
// Module : counter_ctrl_cond_pkg
// Brief  : Shared load-FSM state encoding and parameter defaults for the
//          counter_298A control conditioning stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package counter_ctrl_cond_pkg;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_PRESCALE        = 1;

  // 2'd3 is unused; the FSM treats it as IDLE
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_WAIT_REL = 2'd2
  } load_state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/counter_ctrl_cond_sync_chain.sv
// ============================================================================
// Module : sync_chain
// Brief  : Reset-to-0 multi-stage flop synchronizer, WIDTH bits wide.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sync_chain #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] r_stage [STAGES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_stage[0] <= '0;
    else       r_stage[0] <= din;
  end

  for (genvar i = 1; i < STAGES; i++) begin : g_stage
    always_ff @(posedge clk or posedge reset) begin
      if (reset) r_stage[i] <= '0;
      else       r_stage[i] <= r_stage[i-1];
    end
  end

  assign dout = r_stage[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/counter_ctrl_cond.sv
// ============================================================================
// Module : counter_ctrl_cond
// Brief  : Synchronizes raw pin controls, debounces the load button into a
//          single-cycle strobe with captured data, and rate-limits count enable.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module counter_ctrl_cond
  import counter_ctrl_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int PRESCALE        = DEF_PRESCALE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en_in,
  input  logic       load_in,
  input  logic       up_in,
  input  logic       oe_in,
  input  logic [7:0] d_in,
  output logic       en_out,
  output logic       load_out,
  output logic       up_out,
  output logic       oe_out,
  output logic [7:0] d_out,
  output logic       load_busy
);

  localparam int                CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       w_ctl_sync;
  logic [7:0]       w_sync_d;
  logic             w_sync_en;
  logic             w_sync_load;
  logic             w_tick;
  logic             w_capture;
  logic             r_stable_load;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_d_out;
  load_state_t      r_state;
  load_state_t      w_state_next;

  sync_chain #(.STAGES(SYNC_STAGES), .WIDTH(4)) u_sync_ctl (
    .clk   (clk),
    .reset (reset),
    .din   ({en_in, up_in, oe_in, load_in}),
    .dout  (w_ctl_sync)
  );

  // d skew between bits is harmless: it is only sampled after debounce settles
  sync_chain #(.STAGES(SYNC_STAGES), .WIDTH(8)) u_sync_d (
    .clk   (clk),
    .reset (reset),
    .din   (d_in),
    .dout  (w_sync_d)
  );

  assign w_sync_en   = w_ctl_sync[3];
  assign up_out      = w_ctl_sync[2];
  assign oe_out      = w_ctl_sync[1];
  assign w_sync_load = w_ctl_sync[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stable_load <= 1'b0;
      r_cnt         <= '0;
    end else if (w_sync_load == r_stable_load) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_MAX) begin
      r_stable_load <= w_sync_load;
      r_cnt         <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_stable_load) begin
          w_state_next = ST_ARMED;
          w_capture    = 1'b1;
        end
      end
      ST_ARMED:    w_state_next = ST_WAIT_REL;
      ST_WAIT_REL: if (!r_stable_load) w_state_next = ST_IDLE;
      default:     w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_d_out <= 8'h00;
    else if (w_capture) r_d_out <= w_sync_d;
  end

  if (PRESCALE > 1) begin : g_prescale
    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] P_MAX = PW'(PRESCALE - 1);
    logic [PW-1:0] r_cnt_p;

    always_ff @(posedge clk or posedge reset) begin
      if (reset)               r_cnt_p <= '0;
      else if (r_cnt_p == P_MAX) r_cnt_p <= '0;
      else                     r_cnt_p <= r_cnt_p + 1'b1;
    end

    assign w_tick = (r_cnt_p == P_MAX);
  end else begin : g_no_prescale
    assign w_tick = 1'b1;
  end

  assign load_out  = (r_state == ST_ARMED);
  assign load_busy = (r_state != ST_IDLE);
  assign d_out     = r_d_out;
  // a tick coinciding with the load strobe is dropped, not deferred
  assign en_out    = w_sync_en & w_tick & ~load_out;

endmodule

`default_nettype wire

// File: tb/tb_counter_ctrl_cond.sv
// ============================================================================
// Module : tb_counter_ctrl_cond
// Brief  : Self-checking bench for counter_ctrl_cond (directed + random).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_counter_ctrl_cond;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int N    = 400;

  logic       clk = 1'b0;
  logic       reset;
  logic       en_in, load_in, up_in, oe_in;
  logic [7:0] d_in;

  logic       en_out, load_out, up_out, oe_out, load_busy;
  logic [7:0] d_out;
  logic       p_en_out, p_load_out, p_up_out, p_oe_out, p_load_busy;
  logic [7:0] p_d_out;

  int n_checks = 0;
  int n_fail   = 0;

  bit       lin_h [0:N];
  bit       en_h  [0:N];
  bit       up_h  [0:N];
  bit       oe_h  [0:N];
  bit [7:0] din_h [0:N];
  bit       stab  [0:N];

  always #5 clk = ~clk;

  counter_ctrl_cond #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .PRESCALE(1)) dut (
    .clk(clk), .reset(reset), .en_in(en_in), .load_in(load_in), .up_in(up_in),
    .oe_in(oe_in), .d_in(d_in), .en_out(en_out), .load_out(load_out),
    .up_out(up_out), .oe_out(oe_out), .d_out(d_out), .load_busy(load_busy)
  );

  counter_ctrl_cond #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .PRESCALE(4)) dut_p (
    .clk(clk), .reset(reset), .en_in(en_in), .load_in(load_in), .up_in(up_in),
    .oe_in(oe_in), .d_in(d_in), .en_out(p_en_out), .load_out(p_load_out),
    .up_out(p_up_out), .oe_out(p_oe_out), .d_out(p_d_out), .load_busy(p_load_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [12:0] obs;
    reset = 1'b1; en_in = 1'b1; load_in = 1'b1; up_in = 1'b1; oe_in = 1'b1; d_in = 8'hFF;
    #1;
    obs = {en_out, load_out, up_out, oe_out, load_busy, d_out};
    n_checks++;
    if (obs !== 13'h0) begin
      n_fail++; $display("FAIL reset_async: outputs=%h expected 0", obs);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      obs = {en_out, load_out, up_out, oe_out, load_busy, d_out};
      n_checks++;
      if (obs !== 13'h0) begin
        n_fail++; $display("FAIL reset_hold cyc%0d: outputs=%h expected 0", i, obs);
      end
    end
    en_in = 1'b0; load_in = 1'b0; up_in = 1'b0; oe_in = 1'b0; d_in = 8'h00;
    step();
    reset = 1'b0;
    step(); step(); step();
  endtask

  task automatic test_clean_load();
    d_in = 8'hA5;
    step();
    load_in = 1'b1;
    // the next edge is the first to sample the press; the strobe follows its 7th edge
    for (int n = 1; n <= 20; n++) begin
      step();
      n_checks++;
      if (load_out !== (n == 7)) begin
        n_fail++; $display("FAIL clean_load_pulse n=%0d: load_out=%b expected %b", n, load_out, (n == 7));
      end
      if (n == 7) begin
        n_checks++;
        if (d_out !== 8'hA5) begin
          n_fail++; $display("FAIL clean_load_d: d_out=%h expected a5", d_out);
        end
      end
    end
    load_in = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      step();
      n_checks++;
      if (load_busy !== (n <= 6)) begin
        n_fail++; $display("FAIL clean_load_busy n=%0d: load_busy=%b expected %b", n, load_busy, (n <= 6));
      end
    end
    n_checks++;
    if (d_out !== 8'hA5) begin
      n_fail++; $display("FAIL clean_load_hold: d_out=%h expected a5", d_out);
    end
  endtask

  task automatic test_bounce();
    int bad;
    bad = 0;
    d_in = 8'h3C;
    for (int b = 0; b < 24; b++) begin
      load_in = (b < 12) ? (((b / 3) % 2) == 0) : 1'b0;
      step();
      if (load_out !== 1'b0 || load_busy !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL bounce_no_load: %0d cycles with load activity, expected 0", bad);
    end
    n_checks++;
    if (d_out !== 8'hA5) begin
      n_fail++; $display("FAIL bounce_d: d_out=%h expected a5", d_out);
    end
  endtask

  task automatic test_held_en();
    int pulses;
    pulses = 0;
    en_in = 1'b1; d_in = 8'hC3;
    step(); step(); step();
    load_in = 1'b1;
    for (int n = 1; n <= 50; n++) begin
      step();
      if (load_out === 1'b1) pulses++;
      n_checks++;
      if (en_out !== (n != 7) || load_out !== (n == 7)) begin
        n_fail++;
        $display("FAIL held_en n=%0d: en_out=%b load_out=%b expected en_out=%b load_out=%b",
                 n, en_out, load_out, (n != 7), (n == 7));
      end
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++; $display("FAIL held_single_pulse: pulses=%0d expected 1", pulses);
    end
    load_in = 1'b0;
    for (int n = 0; n < 10; n++) step();
    n_checks++;
    if (load_busy !== 1'b0 || d_out !== 8'hC3) begin
      n_fail++; $display("FAIL held_release: busy=%b d_out=%h expected busy=0 d_out=c3", load_busy, d_out);
    end
  endtask

  task automatic test_prescale();
    int last, highs;
    last = -1; highs = 0;
    en_in = 1'b1;
    step(); step(); step();
    for (int n = 0; n < 40; n++) begin
      step();
      if (p_en_out === 1'b1) begin
        if (last >= 0) begin
          n_checks++;
          if (n - last != 4) begin
            n_fail++; $display("FAIL prescale_period: gap=%0d expected 4", n - last);
          end
        end
        last = n;
        highs++;
      end
    end
    n_checks++;
    if (highs != 10) begin
      n_fail++; $display("FAIL prescale_count: highs=%0d expected 10", highs);
    end
    en_in = 1'b0;
    step(); step(); step();
    for (int n = 0; n < 8; n++) begin
      step();
      n_checks++;
      if (p_en_out !== 1'b0) begin
        n_fail++; $display("FAIL prescale_off n=%0d: en_out=%b expected 0", n, p_en_out);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    bit seen;
    seen = 1'b0;
    d_in = 8'h5A;
    load_in = 1'b1;
    for (int n = 0; n < 20 && !seen; n++) begin
      step();
      if (load_out === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++; $display("FAIL mid_load_timeout: load_out=%b expected 1 within 20 cycles", load_out);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (load_out !== 1'b0 || load_busy !== 1'b0 || d_out !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_load_reset: load_out=%b busy=%b d_out=%h expected 0 0 00", load_out, load_busy, d_out);
    end
    step();
    reset = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      step();
      n_checks++;
      if (load_out !== (n == 7)) begin
        n_fail++; $display("FAIL mid_load_repulse n=%0d: load_out=%b expected %b", n, load_out, (n == 7));
      end
    end
    n_checks++;
    if (d_out !== 8'h5A) begin
      n_fail++; $display("FAIL mid_load_d: d_out=%h expected 5a", d_out);
    end
    load_in = 1'b0;
    for (int n = 0; n < 10; n++) step();
  endtask

  // Model: synced load at edge x is the pin value of edge x-SYNC; the stable
  // level flips once DEB consecutive synced samples disagree with it. A strobe
  // follows each stable rise by one edge, busy is stable delayed by one edge.
  task automatic test_random();
    int          seg_left, errs;
    bit          cur, m, all_diff, sv, p;
    logic [7:0]  exp_d;
    logic [12:0] obs, exp_v;
    seg_left = 0; cur = 1'b0; exp_d = 8'h00; errs = 0;
    reset = 1'b1; en_in = 1'b0; load_in = 1'b0; up_in = 1'b0; oe_in = 1'b0; d_in = 8'h00;
    step();
    reset = 1'b0;
    lin_h[0] = 0; en_h[0] = 0; up_h[0] = 0; oe_h[0] = 0; din_h[0] = 0; stab[0] = 0;
    for (int x = 1; x <= N; x++) begin
      if (seg_left == 0) begin
        cur = ~cur;
        seg_left = $urandom_range(1, 7);
      end
      seg_left--;
      lin_h[x] = cur;
      en_h[x]  = 1'($urandom_range(0, 1));
      up_h[x]  = 1'($urandom_range(0, 1));
      oe_h[x]  = 1'($urandom_range(0, 1));
      din_h[x] = 8'($urandom);
      load_in = lin_h[x]; en_in = en_h[x]; up_in = up_h[x]; oe_in = oe_h[x]; d_in = din_h[x];
      step();
      m = stab[x-1];
      all_diff = 1'b1;
      for (int j = 0; j < DEB; j++) begin
        sv = (x - j - SYNC >= 1) ? lin_h[x - j - SYNC] : 1'b0;
        if (sv == m) all_diff = 1'b0;
      end
      stab[x] = all_diff ? ~m : m;
      p = (x >= 2) ? (stab[x-1] & ~stab[x-2]) : 1'b0;
      if (p) exp_d = din_h[x-SYNC];
      exp_v = {en_h[x-1] & ~p, p, up_h[x-1], oe_h[x-1], stab[x-1], exp_d};
      obs   = {en_out, load_out, up_out, oe_out, load_busy, d_out};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        errs++;
        if (errs <= 10)
          $display("FAIL random x=%0d: {en,load,up,oe,busy,d}=%h expected %h", x, obs, exp_v);
      end
    end
    load_in = 1'b0; en_in = 1'b0;
    for (int n = 0; n < 10; n++) step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; en_in = 1'b0; load_in = 1'b0; up_in = 1'b0; oe_in = 1'b0; d_in = 8'h00;
    test_reset();
    test_clean_load();
    test_bounce();
    test_held_en();
    test_prescale();
    test_reset_mid_load();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
